// File: rtl/fetch_queue_ctrl_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue sequencer.
package fetch_queue_ctrl_pkg;

    localparam int          FQ_DATA_W      = 362;
    localparam logic [31:0] FQ_RESET_PC    = 32'h1c00_0000;
    localparam logic [31:0] FQ_FETCH_BYTES = 32'd8;

    typedef enum logic [0:0] {
        FQ_RUN   = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_e;

endpackage

// File: rtl/fetch_queue_ctrl_chk.sv
// Protocol and credit-invariant properties for fetch_queue_ctrl; bound to the design by its environment.
module fetch_queue_ctrl_chk #(
    parameter int  QCAP         = 4,
    parameter int  MAX_INFLIGHT = 2,
    localparam int OCC_W        = $clog2(QCAP + 1),
    localparam int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input logic             i_clk,
    input logic             i_rst,
    input logic             i_flush,
    input logic             i_deq,
    input logic             i_req_ready,
    input logic             req_valid,
    input logic [31:0]      req_pc,
    input logic [OCC_W-1:0] occ,
    input logic [INF_W-1:0] inflight
);

    // Popping an empty queue is a decode-side protocol error.
    a_no_deq_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        i_deq |-> (occ != '0));

    a_credit: assert property (@(posedge i_clk) disable iff (i_rst)
        (32'(occ) + 32'(inflight)) <= 32'(QCAP));

    // A raised request holds with a stable PC until accepted, unless flushed.
    a_req_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (req_valid && !i_req_ready) |=> (i_flush || (req_valid && (req_pc == $past(req_pc)))));

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Credit-based fetch sequencer: issues fetches only when queue space is guaranteed,
// gates responses into the queue, and drains stale responses after a flush.
module fetch_queue_ctrl
    import fetch_queue_ctrl_pkg::*;
#(
    parameter int          QCAP         = 4,
    parameter int          MAX_INFLIGHT = 2,
    parameter logic [31:0] FETCH_BYTES  = FQ_FETCH_BYTES,
    parameter logic [31:0] RESET_PC     = FQ_RESET_PC,
    localparam int         OCC_W        = $clog2(QCAP + 1),
    localparam int         INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [31:0]      i_flush_pc,
    output logic             o_req_valid,
    output logic [31:0]      o_req_pc,
    input  logic             i_req_ready,
    input  logic             i_resp_valid,
    output logic             o_fifo_w_en,
    output logic             o_fifo_clr,
    input  logic             i_deq,
    output logic [OCC_W-1:0] o_occ,
    output logic [INF_W-1:0] o_inflight
);

    fq_state_e        state_r, state_nxt_s;
    logic [31:0]      pc_r, pc_nxt_s;
    logic [OCC_W-1:0] occ_r, occ_nxt_s;
    logic [INF_W-1:0] inflight_r, inflight_nxt_s, inflight_post_resp_s;
    logic [OCC_W:0]   credit_sum_s;
    logic             can_issue_s;
    logic             req_valid_s;
    logic             fifo_w_en_s;
    logic             fifo_clr_s;
    logic             accept_s;

    assign credit_sum_s = {1'b0, occ_r} + (OCC_W+1)'(inflight_r);
    assign can_issue_s  = (credit_sum_s < (OCC_W+1)'(QCAP)) && (inflight_r < INF_W'(MAX_INFLIGHT));
    assign accept_s     = req_valid_s & i_req_ready;

    // A response with nothing outstanding is ignored rather than wrapping the counter.
    assign inflight_post_resp_s = (i_resp_valid && (inflight_r != '0)) ? (inflight_r - INF_W'(1'b1)) : inflight_r;
    assign inflight_nxt_s       = inflight_post_resp_s + INF_W'(accept_s);

    // Request, queue-write and queue-clear decode; flush overrides everything but reset.
    always_comb begin
        req_valid_s = 1'b0;
        fifo_w_en_s = 1'b0;
        fifo_clr_s  = 1'b0;
        if (i_rst) begin
            req_valid_s = 1'b0;
        end else if (i_flush) begin
            fifo_clr_s = 1'b1;
        end else begin
            case (state_r)
                FQ_RUN: begin
                    req_valid_s = can_issue_s;
                    fifo_w_en_s = i_resp_valid;
                end
                FQ_DRAIN: begin
                    req_valid_s = 1'b0;
                    fifo_w_en_s = 1'b0;
                end
                default: begin
                    req_valid_s = 1'b0;
                    fifo_w_en_s = 1'b0;
                end
            endcase
        end
    end

    // Next PC, occupancy and FSM state.
    always_comb begin
        pc_nxt_s    = pc_r;
        occ_nxt_s   = occ_r;
        state_nxt_s = state_r;
        if (i_flush) begin
            pc_nxt_s    = i_flush_pc;
            occ_nxt_s   = '0;
            state_nxt_s = (inflight_post_resp_s != '0) ? FQ_DRAIN : FQ_RUN;
        end else begin
            pc_nxt_s = accept_s ? (pc_r + FETCH_BYTES) : pc_r;
            if (fifo_w_en_s == i_deq) begin
                occ_nxt_s = occ_r;
            end else if (fifo_w_en_s) begin
                occ_nxt_s = occ_r + OCC_W'(1'b1);
            end else if (occ_r == '0) begin
                occ_nxt_s = occ_r;
            end else begin
                occ_nxt_s = occ_r - OCC_W'(1'b1);
            end
            if ((state_r == FQ_DRAIN) && (inflight_nxt_s == '0)) begin
                state_nxt_s = FQ_RUN;
            end else begin
                state_nxt_s = state_r;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= FQ_RUN;
            pc_r       <= RESET_PC;
            occ_r      <= '0;
            inflight_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            occ_r      <= occ_nxt_s;
            inflight_r <= inflight_nxt_s;
        end
    end

    assign o_req_valid = req_valid_s;
    assign o_req_pc    = pc_r;
    assign o_fifo_w_en = fifo_w_en_s;
    assign o_fifo_clr  = fifo_clr_s;
    assign o_occ       = occ_r;
    assign o_inflight  = inflight_r;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Self-checking bench for fetch_queue_ctrl: fixed vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_fetch_queue_ctrl;

    localparam int QCAP = 4;
    localparam int MAXI = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        o_req_valid;
    logic [31:0] o_req_pc;
    logic        i_req_ready;
    logic        i_resp_valid;
    logic        o_fifo_w_en;
    logic        o_fifo_clr;
    logic        i_deq;
    logic [2:0]  o_occ;
    logic [1:0]  o_inflight;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    fetch_queue_ctrl #(.QCAP(QCAP), .MAX_INFLIGHT(MAXI)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_flush_pc(i_flush_pc),
        .o_req_valid(o_req_valid), .o_req_pc(o_req_pc), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .o_fifo_w_en(o_fifo_w_en), .o_fifo_clr(o_fifo_clr),
        .i_deq(i_deq), .o_occ(o_occ), .o_inflight(o_inflight)
    );

    fetch_queue_ctrl_chk #(.QCAP(QCAP), .MAX_INFLIGHT(MAXI)) chk_i (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_deq(i_deq),
        .i_req_ready(i_req_ready), .req_valid(o_req_valid), .req_pc(o_req_pc),
        .occ(o_occ), .inflight(o_inflight)
    );

    // Reference model: outstanding requests (with a stale mark) and queued entries.
    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] m_pc;

    typedef struct {
        logic        resp;
        logic        deq;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_wen;
        logic [2:0]  e_occ;
        logic [1:0]  e_inf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_draining();
        foreach (pend_q[i]) if (pend_q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        fifo_q.delete();
        m_pc = 32'h1c00_0000;
    endtask

    // One cycle: drive, compare against the model at the falling edge, advance the model.
    task automatic step(input logic fl, input logic [31:0] fpc, input logic rdy,
                        input logic rsp, input logic dq);
        logic  e_valid;
        logic  e_wen;
        pend_t head;
        i_flush = fl; i_flush_pc = fpc; i_req_ready = rdy; i_resp_valid = rsp; i_deq = dq;
        @(negedge i_clk);
        e_valid = !fl && !m_draining() && ((fifo_q.size() + pend_q.size()) < QCAP) && (pend_q.size() < MAXI);
        e_wen   = !fl && rsp && (pend_q.size() > 0) && !pend_q[0].stale;
        chk("req_valid", 32'(o_req_valid), 32'(e_valid));
        chk("req_pc", o_req_pc, m_pc);
        chk("fifo_w_en", 32'(o_fifo_w_en), 32'(e_wen));
        chk("fifo_clr", 32'(o_fifo_clr), 32'(fl));
        chk("occ", 32'(o_occ), 32'(fifo_q.size()));
        chk("inflight", 32'(o_inflight), 32'(pend_q.size()));
        if (dq && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        if (rsp && (pend_q.size() > 0)) begin
            head = pend_q.pop_front();
            if (e_wen) fifo_q.push_back(head.pc);
        end
        if (fl) begin
            fifo_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            m_pc = fpc;
        end else if (e_valid && rdy) begin
            pend_q.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd8;
        end
        @(posedge i_clk);
        #1;
    endtask

    // Hold reset with hostile inputs; the gated outputs must stay low.
    task automatic do_reset();
        i_rst = 1'b1; i_flush = 1'b1; i_flush_pc = 32'hdead_0000;
        i_req_ready = 1'b1; i_resp_valid = 1'b1; i_deq = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            chk("rst req_valid", 32'(o_req_valid), 32'd0);
            chk("rst fifo_w_en", 32'(o_fifo_w_en), 32'd0);
            chk("rst fifo_clr", 32'(o_fifo_clr), 32'd0);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0; i_flush = 1'b0; i_resp_valid = 1'b0;
        model_reset();
    endtask

    initial begin
        logic        fl;
        logic [31:0] fpc;
        i_rst = 1'b1; i_flush = 1'b0; i_flush_pc = 32'h0; i_req_ready = 1'b0;
        i_resp_valid = 1'b0; i_deq = 1'b0;
        model_reset();

        // Instant responses, no deq until the queue fills, then one pop.
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h1c00_0000, 1'b0, 3'd0, 2'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h1c00_0008, 1'b1, 3'd0, 2'd1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h1c00_0010, 1'b1, 3'd1, 2'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h1c00_0018, 1'b1, 3'd2, 2'd1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 3'd3, 2'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 3'd4, 2'd0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 3'd4, 2'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h1c00_0020, 1'b0, 3'd3, 2'd0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 3'd3, 2'd1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 3'd4, 2'd0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            i_req_ready = 1'b1; i_flush = 1'b0;
            i_resp_valid = vecs[i].resp; i_deq = vecs[i].deq;
            @(negedge i_clk);
            chk("vec req_valid", 32'(o_req_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) chk("vec req_pc", o_req_pc, vecs[i].e_pc);
            chk("vec fifo_w_en", 32'(o_fifo_w_en), 32'(vecs[i].e_wen));
            chk("vec occ", 32'(o_occ), 32'(vecs[i].e_occ));
            chk("vec inflight", 32'(o_inflight), 32'(vecs[i].e_inf));
            @(posedge i_clk);
            #1;
        end

        // Responses withheld, then one response, then flush with two in flight.
        do_reset();
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("withheld inflight", 32'(o_inflight), 32'd2);
        chk("withheld req_valid", 32'(o_req_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("one resp occ", 32'(o_occ), 32'd1);
        chk("one resp inflight", 32'(o_inflight), 32'd1);
        chk("one resp new req", 32'(o_req_valid), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h1c00_1000, 1'b1, 1'b0, 1'b0);
        chk("flush occ", 32'(o_occ), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("post drain valid", 32'(o_req_valid), 32'd1);
        chk("post drain pc", o_req_pc, 32'h1c00_1000);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Back-pressure holds the first request.
        do_reset();
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("accepted after stall", o_req_pc, 32'h1c00_0008);

        // Flush with nothing in flight and three entries queued.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("pre flush occ", 32'(o_occ), 32'd3);
        step(1'b1, 32'h1c00_4000, 1'b0, 1'b0, 1'b0);
        chk("idle flush occ", 32'(o_occ), 32'd0);
        chk("idle flush inflight", 32'(o_inflight), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Flush during drain: the later target wins.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h1c00_1000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h1c00_2000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("double flush valid", 32'(o_req_valid), 32'd1);
        chk("double flush pc", o_req_pc, 32'h1c00_2000);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Response, deq and accept in the same cycle.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("simul occ", 32'(o_occ), 32'd1);
        chk("simul inflight", 32'(o_inflight), 32'd1);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            fl  = ($urandom_range(0, 24) == 0);
            fpc = ($urandom_range(0, 3) == 0) ? 32'hffff_fff0 : ($urandom & 32'hffff_fff8);
            step(fl, fpc, 1'($urandom_range(0, 1)),
                 (pend_q.size() > 0) && ($urandom_range(0, 2) != 0),
                 (fifo_q.size() > 0) && ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_ctrl.md
Name: fetch_queue_ctrl

Overview:
Credit-based sequencer for the 362-bit FWFT instruction queue between fetch and decode. It issues fetch requests only when queue space is guaranteed, gates fetch responses into the queue write port, and tracks queue occupancy. On a pipeline flush it clears the queue, then drains and discards stale in-flight responses before fetching from the redirect PC.

Parameters:
QCAP, 4, guaranteed queue capacity in entries; equals the queue DEPTH.
MAX_INFLIGHT, 2, maximum accepted-but-unanswered fetch requests.
FETCH_BYTES, 8, PC increment per accepted request.
RESET_PC, 32'h1c000000, fetch PC after reset.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_flush  in  1  redirect pulse from backend
i_flush_pc  in  32  redirect target, valid with i_flush
o_req_valid  out  1  fetch request valid
o_req_pc  out  32  fetch request PC
i_req_ready  in  1  fetch unit accepts request
i_resp_valid  in  1  fetch response returned, in request order
o_fifo_w_en  out  1  queue write enable; response data is wired directly to the queue
o_fifo_clr  out  1  one-cycle queue clear, ORed into the queue's i_rst
i_deq  in  1  decode pops an entry (queue r_en && !o_buf_empty)
o_occ  out  clog2(QCAP+1)  tracked occupancy, for debug and performance
o_inflight  out  clog2(MAX_INFLIGHT+1)  outstanding request count

Behaviour:
- Reset: state=RUN, pc=RESET_PC, occ=0, inflight=0. o_req_valid=0, o_fifo_w_en=0, o_fifo_clr=0 during reset.
- States:
  - RUN: normal fetch.
  - DRAIN: discard stale responses.
- Credit rule: can_issue = (occ+inflight < QCAP) && (inflight < MAX_INFLIGHT).
- In RUN with no i_flush, o_req_valid = can_issue.
  - can_issue can only fall through a handshake, so once valid is raised it stays high with a stable o_req_pc until accepted.
  - A flush is the only allowed abort of a pending request.
- Accept (o_req_valid && i_req_ready): pc += FETCH_BYTES (mod 2^32), inflight += 1.
- Response: inflight -= 1.
  - In RUN without flush: o_fifo_w_en = i_resp_valid (combinational, same cycle) and occ += 1.
  - In DRAIN: the response is dropped and o_fifo_w_en=0.
- Accept and response in the same cycle: inflight unchanged.
- i_deq: occ -= 1. Write and deq in the same cycle: occ unchanged.
- i_deq with occ=0 is a protocol error: occ saturates at 0; assertion in simulation.
- The credit invariant guarantees occ+inflight ≤ QCAP, so the queue never overflows; the queue's almost_full/full outputs are unused.
- i_flush (highest priority, any state):
  - Same cycle: o_req_valid=0, o_fifo_w_en=0, o_fifo_clr=1.
  - Next cycle: pc=i_flush_pc and occ=0; a concurrent i_deq or response is ignored for occ.
  - inflight at the next edge = current inflight minus the response this cycle (if any). No accept occurs, since valid is forced low.
  - Next state = DRAIN if that inflight > 0, else RUN. The first request for the new PC can therefore appear the cycle after the flush.
- DRAIN: o_req_valid=0. When the last stale response arrives (inflight 1→0), the state goes to RUN and requesting resumes the following cycle.
- Flush during DRAIN: pc is overwritten with the new target, state stays DRAIN, o_fifo_clr pulses again.
- Back-to-back flushes: the last flush_pc wins.
- o_fifo_clr is asserted for exactly the flush cycle(s). The queue is empty from the next cycle.

Decomposition:
- A shared package holds:
  - FQ_DATA_W = 362
  - state enum {FQ_RUN, FQ_DRAIN}
  - RESET_PC
  - FETCH_BYTES
- The block is a single module with no sub-module: the counters and the 2-state FSM are small.
- A top-level wrapper instantiates this block alongside sync_fifo.

Test Plan:
- Reset, i_req_ready=1, instant responses, no deq:
  - Accepted PCs 1c000000, 1c000008, 1c000010, 1c000018.
  - o_req_valid then stays 0 with occ=4.
  - One i_deq → exactly one further request, PC 1c000020.
- Responses withheld, i_req_ready=1:
  - Exactly 2 accepts (MAX_INFLIGHT), o_inflight=2, o_req_valid=0.
  - One response → o_fifo_w_en pulses, occ=1, inflight=1, one new request.
- i_req_ready=0 for 5 cycles:
  - o_req_valid stays 1 and o_req_pc stable at 1c000000.
  - Accepted on the cycle i_req_ready=1.
- Flush with inflight=2, target 1c001000:
  - o_fifo_clr=1 for one cycle, occ=0, state DRAIN.
  - Two later responses give o_fifo_w_en=0.
  - The cycle after the second response, o_req_pc=1c001000 valid.
- Flush with inflight=0 and occ=3:
  - Next cycle occ=0.
  - The following cycle o_req_valid=1 with the new PC.
- Flush in DRAIN, then a second flush to 1c002000:
  - After the drain, the first request is 1c002000.
- Simultaneous response, deq and accept in one cycle: occ and inflight both unchanged.
